csr_access_unit: RTL and testbench

//  Initiator side of the CSR register-file interface. Executes Zicsr ops (CSRRW/S/C and

---
 rtl/csr_access_unit_pkg.sv | 24 ++
 rtl/csr_access_unit_if.sv | 37 +++
 rtl/csr_access_unit_rmw_alu.sv | 32 +++
 rtl/csr_access_unit.sv | 95 +++++++++
 tb/tb_csr_access_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - shared op encodings, FSM states and address helpers
package csr_access_unit_pkg;

  // Zicsr funct3 encodings; 000 and 100 are not CSR ops and are reported illegal
  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // CSR addresses whose top two bits are 11 are read-only
  function automatic logic csr_is_ro(input logic [1:0] addr_hi);
    return addr_hi == 2'b11;
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - EX request/response and CSR file bus bundle
interface csr_access_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_rs1_idx;
  logic [DATA_W-1:0] req_rs1_val;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_illegal;
  logic [ADDR_W-1:0] csr_raddr;
  logic [DATA_W-1:0] csr_rdata;
  logic              csr_we;
  logic [ADDR_W-1:0] csr_waddr;
  logic [DATA_W-1:0] csr_wdata;

  // Access unit view: accepts requests, issues responses, drives the CSR file
  modport master (
    input  req_valid, req_op, req_addr, req_rs1_idx, req_rs1_val, resp_ready, csr_rdata,
    output req_ready, resp_valid, resp_rdata, resp_illegal, csr_raddr, csr_we, csr_waddr,
    output csr_wdata
  );

  // Environment view: EX stage plus the CSR file
  modport slave (
    output req_valid, req_op, req_addr, req_rs1_idx, req_rs1_val, resp_ready, csr_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_illegal, csr_raddr, csr_we, csr_waddr,
    input  csr_wdata
  );

endinterface

// File: rtl/csr_access_unit_rmw_alu.sv
// rtl/csr_access_unit_rmw_alu.sv - combinational read-modify-write and legality check
module csr_access_unit_rmw_alu
  import csr_access_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RO_CHECK = 1
) (
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] src,
  input  logic [2:0]        op,
  input  logic [4:0]        rs1_idx,
  input  logic [1:0]        addr_hi,
  output logic [DATA_W-1:0] new_val,
  output logic              do_wr,
  output logic              illegal
);

  // New CSR value, write intent and legality for the latched op
  always_comb begin
    new_val = src;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: new_val = src;
      CSR_OP_RS, CSR_OP_RSI: new_val = old | src;
      CSR_OP_RC, CSR_OP_RCI: new_val = old & ~src;
      default:               new_val = src;
    endcase
    // Plain writes always write; set/clear with x0 or uimm 0 are pure reads
    do_wr   = (op[1:0] == 2'b01) || (rs1_idx != 5'd0);
    illegal = (op[1:0] == 2'b00) || ((RO_CHECK != 0) && do_wr && csr_is_ro(addr_hi));
  end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - multi-cycle Zicsr read-modify-write initiator
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RO_CHECK = 1
) (
  input logic               clk,
  input logic               rst,
  csr_access_unit_if.master bus
);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        idx_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] new_q;
  logic              illegal_q;

  logic [DATA_W-1:0] alu_new;
  logic              alu_do_wr;
  logic              alu_illegal;

  csr_access_unit_rmw_alu #(
    .DATA_W   (DATA_W),
    .RO_CHECK (RO_CHECK)
  ) u_alu (
    .old     (bus.csr_rdata),
    .src     (src_q),
    .op      (op_q),
    .rs1_idx (idx_q),
    .addr_hi (addr_q[ADDR_W-1:ADDR_W-2]),
    .new_val (alu_new),
    .do_wr   (alu_do_wr),
    .illegal (alu_illegal)
  );

  // State register plus request latch on accept and RMW capture during READ
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      src_q     <= '0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            addr_q <= bus.req_addr;
            idx_q  <= bus.req_rs1_idx;
            src_q  <= bus.req_op[2] ? {{(DATA_W-5){1'b0}}, bus.req_rs1_idx} : bus.req_rs1_val;
          end
        end
        S_READ: begin
          old_q     <= bus.csr_rdata;
          new_q     <= alu_new;
          illegal_q <= alu_illegal;
        end
        default: ;
      endcase
    end
  end

  // Next-state: READ branches on whether a legal write is needed
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_READ;
      S_READ:  state_d = (alu_do_wr && !alu_illegal) ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.resp_valid   = (state_q == S_RESP);
  assign bus.resp_rdata   = (state_q == S_RESP && !illegal_q) ? old_q : '0;
  assign bus.resp_illegal = (state_q == S_RESP) && illegal_q;
  assign bus.csr_raddr    = addr_q;
  assign bus.csr_waddr    = addr_q;
  assign bus.csr_wdata    = new_q;
  // The CSR file captures on the falling edge, so reset must cancel a write already in WRITE
  assign bus.csr_we       = (state_q == S_WRITE) && !rst;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - self-checking bench for csr_access_unit
module tb_csr_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_unit_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  csr_access_unit #(.ADDR_W(12), .DATA_W(32), .RO_CHECK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // CSR file: combinational read, write on the falling edge
  logic [31:0] csr_mem [0:4095];
  assign bus.csr_rdata = csr_mem[bus.csr_raddr];
  always @(negedge clk) if (bus.csr_we) csr_mem[bus.csr_waddr] = bus.csr_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          in_flight = 0;
  logic [31:0] m_rdata, m_new;
  bit          m_ill, m_wr;
  logic [11:0] m_addr;
  int          txn_wr, resp_cycles;
  logic [31:0] got_rdata, got_wdata;
  bit          got_ill;
  int          got_lat, got_wr, got_resp_cycles;

  // Architectural effect of a Zicsr op on a CSR holding 'old'
  task automatic model_op(input logic [2:0] op, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] val, input logic [31:0] old);
    logic [31:0] s;
    bit writes, bad;
    s = val;
    if (op >= 3'd5) s = 32'(idx);
    case (op)
      3'd1, 3'd5: begin m_new = s;          writes = 1; end
      3'd2, 3'd6: begin m_new = old | s;    writes = (idx != 0); end
      3'd3, 3'd7: begin m_new = old & ~s;   writes = (idx != 0); end
      default:    begin m_new = 0;          writes = (idx != 0); end
    endcase
    bad = (op == 3'd0) || (op == 3'd4) || (writes && a >= 12'hC00);
    m_ill   = bad;
    m_wr    = writes && !bad;
    m_rdata = bad ? 32'd0 : old;
    m_addr  = a;
  endtask

  // Compare process: checks DUT outputs against the model every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0;
    end else begin
      cyc++;
      chk("req_ready", 32'(bus.req_ready), 32'(!in_flight));
      chk("csr_we", 32'(bus.csr_we), 32'(in_flight && m_wr && (cyc - acc_cyc == 2)));
      if (bus.csr_we) begin
        txn_wr++;
        got_wdata = bus.csr_wdata;
        chk("csr_waddr", 32'(bus.csr_waddr), 32'(m_addr));
        chk("csr_wdata", bus.csr_wdata, m_new);
      end
      chk("resp_valid", 32'(bus.resp_valid),
          32'(in_flight && (cyc - acc_cyc >= (m_wr ? 3 : 2))));
      if (bus.resp_valid) begin
        if (resp_cycles == 0) got_lat = cyc - acc_cyc;
        resp_cycles++;
        chk("resp_rdata", bus.resp_rdata, m_rdata);
        chk("resp_illegal", 32'(bus.resp_illegal), 32'(m_ill));
        if (bus.resp_ready) begin
          got_rdata = bus.resp_rdata;
          got_ill = bus.resp_illegal;
          got_wr = txn_wr;
          got_resp_cycles = resp_cycles;
          in_flight = 0;
        end
      end else if (!in_flight && bus.req_valid && bus.req_ready) begin
        model_op(bus.req_op, bus.req_addr, bus.req_rs1_idx, bus.req_rs1_val,
                 csr_mem[bus.req_addr]);
        in_flight = 1;
        acc_cyc = cyc;
        txn_wr = 0;
        resp_cycles = 0;
        got_wdata = 0;
      end
    end
  end

  // Issue one op from posedge+1, hold resp_ready low for 'hold' extra RESP cycles
  task automatic run_op(input logic [2:0] op, input logic [11:0] a, input logic [4:0] idx,
                        input logic [31:0] v, input int hold);
    int n;
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_rs1_idx = idx;
    bus.req_rs1_val = v;
    bus.req_valid = 1'b1;
    bus.resp_ready = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.resp_valid) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      repeat (hold) begin @(posedge clk); #1; end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
    end
  endtask

  // Hand-computed literal expectations for the last completed transaction
  task automatic expect_txn(input string name, input logic [31:0] rdata, input bit ill,
                            input int lat, input int wr, input logic [31:0] wdata, input int rc);
    chk({name, ".rdata"}, got_rdata, rdata);
    chk({name, ".illegal"}, 32'(got_ill), 32'(ill));
    chk({name, ".latency"}, 32'(got_lat), 32'(lat));
    chk({name, ".writes"}, 32'(got_wr), 32'(wr));
    chk({name, ".wdata"}, got_wdata, wdata);
    chk({name, ".resp_cycles"}, 32'(got_resp_cycles), 32'(rc));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({name, ".resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({name, ".resp_illegal"}, 32'(bus.resp_illegal), 32'd0);
    chk({name, ".csr_we"}, 32'(bus.csr_we), 32'd0);
    chk({name, ".resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({name, ".csr_raddr"}, 32'(bus.csr_raddr), 32'd0);
    chk({name, ".csr_waddr"}, 32'(bus.csr_waddr), 32'd0);
    chk({name, ".csr_wdata"}, bus.csr_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_addr = 12'd0;
    bus.req_rs1_idx = 5'd0;
    bus.req_rs1_val = 32'd0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    csr_mem[12'h340] = 32'h12345678;
    run_op(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 0);
    expect_txn("rw_340", 32'h12345678, 0, 3, 1, 32'hDEADBEEF, 1);
    chk("rw_340.mem", csr_mem[12'h340], 32'hDEADBEEF);

    csr_mem[12'h300] = 32'h00000088;
    run_op(3'b010, 12'h300, 5'd0, 32'h0000FFFF, 0);
    expect_txn("rs_x0", 32'h00000088, 0, 2, 0, 32'h0, 1);
    chk("rs_x0.mem", csr_mem[12'h300], 32'h00000088);

    csr_mem[12'h300] = 32'h000000FF;
    run_op(3'b111, 12'h300, 5'd5, 32'hFFFFFFFF, 0);
    expect_txn("rci_5", 32'h000000FF, 0, 3, 1, 32'h000000FA, 1);

    csr_mem[12'hC00] = 32'h00000777;
    run_op(3'b001, 12'hC00, 5'd1, 32'h00000001, 0);
    expect_txn("rw_ro", 32'h0, 1, 2, 0, 32'h0, 1);
    chk("rw_ro.mem", csr_mem[12'hC00], 32'h00000777);
    run_op(3'b100, 12'h300, 5'd1, 32'h00000001, 0);
    expect_txn("op100", 32'h0, 1, 2, 0, 32'h0, 1);
    run_op(3'b010, 12'hC00, 5'd0, 32'hFFFFFFFF, 0);
    expect_txn("rs_x0_ro", 32'h00000777, 0, 2, 0, 32'h0, 1);
    run_op(3'b101, 12'hC00, 5'd0, 32'h0, 0);
    expect_txn("rwi0_ro", 32'h0, 1, 2, 0, 32'h0, 1);

    csr_mem[12'h310] = 32'hFFFF0000;
    run_op(3'b101, 12'h310, 5'h15, 32'hFFFFFFFF, 0);
    expect_txn("rwi_zext", 32'hFFFF0000, 0, 3, 1, 32'h00000015, 1);

    csr_mem[12'h305] = 32'h00000001;
    run_op(3'b001, 12'h305, 5'd2, 32'hCAFE0001, 4);
    expect_txn("rw_hold", 32'h00000001, 0, 3, 1, 32'hCAFE0001, 5);
    run_op(3'b010, 12'h305, 5'd0, 32'h0, 0);
    expect_txn("raw_read", 32'hCAFE0001, 0, 2, 0, 32'h0, 1);
    run_op(3'b110, 12'h305, 5'h1F, 32'h0, 0);
    expect_txn("rsi_1f", 32'hCAFE0001, 0, 3, 1, 32'hCAFE001F, 1);

    csr_mem[12'h306] = 32'h0000F0F0;
    run_op(3'b011, 12'h306, 5'd3, 32'h000000FF, 0);
    expect_txn("rc_reg", 32'h0000F0F0, 0, 3, 1, 32'h0000F000, 1);

    // Reset asserted while the unit sits in WRITE: the pending write must be dropped
    csr_mem[12'h341] = 32'h00000011;
    bus.req_op = 3'b001;
    bus.req_addr = 12'h341;
    bus.req_rs1_idx = 5'd1;
    bus.req_rs1_val = 32'h00000055;
    bus.req_valid = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_write.we", 32'(bus.csr_we), 32'd0);
    @(posedge clk); #1;
    check_reset_outputs("rst_write");
    chk("rst_write.mem", csr_mem[12'h341], 32'h00000011);
    rst = 1'b0;
    bus.resp_ready = 1'b0;
    run_op(3'b010, 12'h341, 5'd0, 32'h0, 0);
    expect_txn("post_rst", 32'h00000011, 0, 2, 0, 32'h0, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
